// File: rtl/mesi_pkg.sv
// ---------------------------------------------------------------------------
// mesi_pkg
// Shared encodings for the MESI snooping bus arbiter slice.
//   bus_op_t        : 2-bit bus operation carried on req_op / bus_op
//   snoop_result_t  : 2-bit combined snoop result returned with done
//   arb_state_t     : arbiter transaction states
//   SNOOP_CNT_W     : width of the snoop-phase cycle counter (covers 1..15)
// ---------------------------------------------------------------------------
package mesi_pkg;

  // Bus operations requested by a cache and broadcast on the snoop bus.
  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_RWITM      = 2'b01,
    OP_INVALIDATE = 2'b10,
    OP_WRITEBACK  = 2'b11
  } bus_op_t;

  // Combined snoop outcome reported to the requesting cache.
  typedef enum logic [1:0] {
    RES_NOHIT = 2'b00,
    RES_HIT   = 2'b01,
    RES_HITM  = 2'b10
  } snoop_result_t;

  // One transaction walks IDLE -> ADDR -> (SNOOP -> (WB) ->) DONE -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_SNOOP = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  // Snoop latency is at most 15 cycles, so a 4-bit counter is enough.
  localparam int SNOOP_CNT_W = 4;

endpackage

// File: rtl/mesi_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. The search starts at index
// ptr and wraps around, so requesters at or above ptr win before lower ones.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  IDX_W  index with highest priority this round
//   gnt   out N_REQ  one-hot grant (all zero when nothing requests)
//   idx   out IDX_W  binary index of the granted requester
//   valid out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
  import mesi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters in rotated order (ptr, ptr+1, ... wrapping) and keep
  // the first one that is requesting; later candidates are ignored once a
  // winner has been found.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mesi_bus_arbiter
// Single-transaction snooping bus arbiter for a MESI cache cluster. Picks a
// requesting cache round-robin, broadcasts its op/address for one cycle,
// waits SNOOP_LAT cycles, samples the other caches' snoop responses, pulls a
// writeback from a Modified owner if needed, then pulses done with the
// combined snoop result. All outputs are registered.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   req/req_op/req_addr   per-cache request, op (2b each), line address
//   gnt              one-hot grant, held from address phase through done
//   done, result     one-cycle completion pulse and snoop result with it
//   bus_valid/op/addr/src broadcast snoop bus, zero when not valid
//   snoop_hit/hitm   per-cache snoop responses
//   wb_req, wb_done  writeback handshake with the owning cache
//   err              one-cycle pulse on inconsistent snoop responses
// ---------------------------------------------------------------------------
module mesi_bus_arbiter
  import mesi_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 32,
  parameter int SNOOP_LAT = 2,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [2*N_REQ-1:0]        req_op,
  input  logic [ADDR_W*N_REQ-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [1:0]                result,
  output logic                      bus_valid,
  output logic [1:0]                bus_op,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic [IDX_W-1:0]          bus_src,
  input  logic [N_REQ-1:0]          snoop_hit,
  input  logic [N_REQ-1:0]          snoop_hitm,
  output logic [N_REQ-1:0]          wb_req,
  input  logic [N_REQ-1:0]          wb_done,
  output logic                      err
);

  localparam logic [SNOOP_CNT_W-1:0] LAST_CNT = SNOOP_CNT_W'(SNOOP_LAT - 1);

  arb_state_t               state;
  logic [IDX_W-1:0]         ptr;
  logic [SNOOP_CNT_W-1:0]   snoop_cnt;
  logic [N_REQ-1:0]         win_oh;
  bus_op_t                  win_op;

  logic [N_REQ-1:0]         arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     arb_valid;
  logic [IDX_W-1:0]         ptr_next;
  logic [1:0]               sel_op;
  logic [ADDR_W-1:0]        sel_addr;

  logic [N_REQ-1:0]         hit_m;
  logic [N_REQ-1:0]         hitm_m;
  logic [N_REQ-1:0]         owner_oh;
  logic                     multi_hitm;
  logic                     proto_err;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Pointer moves just past the winner so it gets lowest priority next time.
  assign ptr_next = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

  // Pull the winner's op and address out of the packed request buses using
  // the one-hot grant, which keeps every slice at a constant offset.
  always_comb begin
    sel_op   = '0;
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // The requester's own snoop response is meaningless, so it is masked off.
  // owner_oh isolates the lowest set hitm bit (x & -x); multi_hitm is set
  // when clearing that lowest bit still leaves another hitm behind.
  assign hit_m      = snoop_hit  & ~win_oh;
  assign hitm_m     = snoop_hitm & ~win_oh;
  assign owner_oh   = hitm_m & (~hitm_m + N_REQ'(1));
  assign multi_hitm = (hitm_m & (hitm_m - N_REQ'(1))) != '0;
  assign proto_err  = multi_hitm || ((hitm_m != '0) && (hit_m != '0));

  // Transaction FSM. Every output is a register updated on the transition
  // into the state where it must be visible, so a grant taken in IDLE shows
  // up on the bus in the ADDR cycle, and done/result appear in DONE. The
  // request inputs are only looked at in IDLE, so the in-flight transaction
  // is immune to requesters dropping or changing their request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      snoop_cnt <= '0;
      win_oh    <= '0;
      win_op    <= OP_READ;
      gnt       <= '0;
      done      <= '0;
      result    <= RES_NOHIT;
      bus_valid <= 1'b0;
      bus_op    <= '0;
      bus_addr  <= '0;
      bus_src   <= '0;
      wb_req    <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            state     <= ST_ADDR;
            ptr       <= ptr_next;
            win_oh    <= arb_gnt;
            win_op    <= bus_op_t'(sel_op);
            gnt       <= arb_gnt;
            bus_valid <= 1'b1;
            bus_op    <= sel_op;
            bus_addr  <= sel_addr;
            bus_src   <= arb_idx;
          end
        end

        ST_ADDR: begin
          bus_valid <= 1'b0;
          bus_op    <= '0;
          bus_addr  <= '0;
          bus_src   <= '0;
          if (win_op == OP_WRITEBACK) begin
            // A writeback of our own line needs no snoop round.
            state  <= ST_DONE;
            done   <= win_oh;
            result <= RES_NOHIT;
          end else begin
            state     <= ST_SNOOP;
            snoop_cnt <= '0;
          end
        end

        ST_SNOOP: begin
          if (snoop_cnt == LAST_CNT) begin
            snoop_cnt <= '0;
            err       <= proto_err;
            if (hitm_m != '0) begin
              state  <= ST_WB;
              wb_req <= owner_oh;
            end else begin
              state  <= ST_DONE;
              done   <= win_oh;
              result <= (hit_m != '0) ? RES_HIT : RES_NOHIT;
            end
          end else begin
            snoop_cnt <= snoop_cnt + SNOOP_CNT_W'(1);
          end
        end

        ST_WB: begin
          // Only the owner we asked may finish the writeback.
          if ((wb_done & wb_req) != '0) begin
            wb_req <= '0;
            state  <= ST_DONE;
            done   <= win_oh;
            result <= RES_HITM;
          end
        end

        ST_DONE: begin
          done   <= '0;
          result <= RES_NOHIT;
          gnt    <= '0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mesi_bus_arbiter
// Directed plus randomized bench for mesi_bus_arbiter (N_REQ=4, ADDR_W=32,
// SNOOP_LAT=2). Expected behaviour comes from a transaction-level model:
// round-robin winner from a pointer, snoop outcome from the masked response
// vectors, and fixed per-phase cycle positions.
// ---------------------------------------------------------------------------
module tb_mesi_bus_arbiter;

  localparam int N_REQ     = 4;
  localparam int ADDR_W    = 32;
  localparam int SNOOP_LAT = 2;

  logic                     clk_tb = 1'b0;
  logic                     reset;
  logic [N_REQ-1:0]         req;
  logic [2*N_REQ-1:0]       req_op;
  logic [ADDR_W*N_REQ-1:0]  req_addr;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         done;
  logic [1:0]               result;
  logic                     bus_valid;
  logic [1:0]               bus_op;
  logic [ADDR_W-1:0]        bus_addr;
  logic [1:0]               bus_src;
  logic [N_REQ-1:0]         snoop_hit;
  logic [N_REQ-1:0]         snoop_hitm;
  logic [N_REQ-1:0]         wb_req;
  logic [N_REQ-1:0]         wb_done;
  logic                     err;

  int check_count = 0;
  int error_count = 0;
  int ptr_model   = 0;

  logic [1:0]        op_tbl   [N_REQ];
  logic [ADDR_W-1:0] addr_tbl [N_REQ];

  mesi_bus_arbiter #(
    .N_REQ     (N_REQ),
    .ADDR_W    (ADDR_W),
    .SNOOP_LAT (SNOOP_LAT)
  ) dut (
    .clk        (clk_tb),
    .reset      (reset),
    .req        (req),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .bus_valid  (bus_valid),
    .bus_op     (bus_op),
    .bus_addr   (bus_addr),
    .bus_src    (bus_src),
    .snoop_hit  (snoop_hit),
    .snoop_hitm (snoop_hitm),
    .wb_req     (wb_req),
    .wb_done    (wb_done),
    .err        (err)
  );

  // Free-running clock; all checks and input changes happen on the falling
  // edge so they sit half a period away from the DUT's active edge.
  always #5 clk_tb = ~clk_tb;

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the request and snoop inputs, packing per-cache op/addr tables.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] h,
                               input logic [3:0] hm);
    req        = r;
    snoop_hit  = h;
    snoop_hitm = hm;
    for (int i = 0; i < N_REQ; i++) begin
      req_op[2*i +: 2]            = op_tbl[i];
      req_addr[ADDR_W*i +: ADDR_W] = addr_tbl[i];
    end
  endtask

  // Round-robin rule: first requester found scanning upward from the pointer.
  function automatic int pick_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  // Runs one full transaction from an IDLE cycle to the following IDLE
  // cycle, checking every phase against the model's expectations.
  task automatic doTxn(input logic [3:0] r, input logic [3:0] h,
                       input logic [3:0] hm, input int wb_delay,
                       input bit hold_req, input bit mutate);
    int          w;
    int          owner;
    int          n_hitm;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [3:0]  oh;
    logic [3:0]  own_oh;
    logic [3:0]  m_hit;
    logic [3:0]  m_hitm;
    logic [1:0]  exp_res;
    logic        exp_err;

    w    = pick_winner(r, ptr_model);
    op   = op_tbl[w];
    addr = addr_tbl[w];
    oh   = 4'(1 << w);

    m_hit  = h  & ~oh;
    m_hitm = hm & ~oh;
    n_hitm = $countones(m_hitm);
    owner  = -1;
    for (int i = N_REQ - 1; i >= 0; i--) if (m_hitm[i]) owner = i;
    own_oh  = (owner >= 0) ? 4'(1 << owner) : 4'b0;
    exp_err = (n_hitm > 1) || (n_hitm > 0 && m_hit != 4'b0);
    exp_res = (m_hit != 4'b0) ? 2'b01 : 2'b00;

    applyStimulus(r, h, hm);
    checkOutput("idle_gnt", {gnt, bus_valid}, 0);

    @(negedge clk_tb);
    checkOutput("addr_gnt", {gnt, done}, {oh, 4'b0});
    checkOutput("addr_bus", {bus_valid, bus_op, bus_src, bus_addr},
                {1'b1, op, 2'(w), addr});

    // Changing or dropping the request after latching must not matter.
    if (mutate) begin
      for (int i = 0; i < N_REQ; i++) begin
        op_tbl[i]   = 2'($urandom);
        addr_tbl[i] = $urandom;
      end
    end
    applyStimulus(hold_req ? r : 4'b0, h, hm);

    if (op == 2'b11) begin
      @(negedge clk_tb);
      checkOutput("wbk_done", {gnt, done, result, bus_valid, wb_req, err},
                  {oh, oh, 2'b00, 1'b0, 4'b0, 1'b0});
    end else begin
      for (int k = 0; k < SNOOP_LAT; k++) begin
        @(negedge clk_tb);
        checkOutput("snoop_wait", {gnt, done, result, bus_valid, bus_addr, wb_req, err},
                    {oh, 4'b0, 2'b00, 1'b0, 32'b0, 4'b0, 1'b0});
      end
      @(negedge clk_tb);
      if (owner >= 0) begin
        checkOutput("wb_enter", {gnt, done, result, wb_req, err},
                    {oh, 4'b0, 2'b00, own_oh, exp_err});
        for (int k = 0; k < wb_delay; k++) begin
          wb_done = 4'($urandom) & ~own_oh;
          @(negedge clk_tb);
          checkOutput("wb_hold", {gnt, done, wb_req, err},
                      {oh, 4'b0, own_oh, 1'b0});
        end
        wb_done = own_oh | (4'($urandom) & ~own_oh);
        @(negedge clk_tb);
        wb_done = 4'b0;
        checkOutput("wb_finish", {gnt, done, result, wb_req, err},
                    {oh, oh, 2'b10, 4'b0, 1'b0});
      end else begin
        checkOutput("snoop_done", {gnt, done, result, wb_req, err},
                    {oh, oh, exp_res, 4'b0, exp_err});
      end
    end

    @(negedge clk_tb);
    ptr_model = (w + 1) % N_REQ;
    checkOutput("post_idle", {gnt, done, result, bus_valid, wb_req, err}, 0);
  endtask

  // Linear test sequence: reset, directed scenarios, random traffic, then a
  // reset in the middle of a writeback.
  initial begin
    logic [3:0] r;
    logic [3:0] h;
    logic [3:0] hm;

    reset   = 1'b1;
    wb_done = 4'b0;
    for (int i = 0; i < N_REQ; i++) begin
      op_tbl[i]   = 2'b00;
      addr_tbl[i] = 32'h100 * (i + 1);
    end
    applyStimulus(4'b0, 4'b0, 4'b0);
    repeat (2) @(negedge clk_tb);
    checkOutput("reset_state",
                {gnt, done, result, bus_valid, bus_op, bus_addr, bus_src, wb_req, err}, 0);
    reset = 1'b0;
    @(negedge clk_tb);
    checkOutput("idle_after_reset", {gnt, done, bus_valid, wb_req, err}, 0);

    // All four caches request and keep requesting: order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) doTxn(4'b1111, 4'b0, 4'b0, 0, 1'b1, 1'b0);

    // Single READ from cache 0 at 0x40 with no snoop hits.
    op_tbl[0]   = 2'b00;
    addr_tbl[0] = 32'h40;
    doTxn(4'b0001, 4'b0, 4'b0, 0, 1'b0, 1'b0);
    // Pointer is now 1, so cache 1 beats cache 0.
    doTxn(4'b0011, 4'b0, 4'b0, 0, 1'b0, 1'b0);

    // Cache 3 WRITEBACK completes right after the address phase.
    op_tbl[3] = 2'b11;
    doTxn(4'b1000, 4'b1111, 4'b0110, 0, 1'b0, 1'b0);

    // Cache 2 RWITM hits a Modified copy in cache 1.
    op_tbl[2] = 2'b01;
    doTxn(4'b0100, 4'b0, 4'b0010, 5, 1'b0, 1'b0);

    // Cache 0 READ: its own hit bit is masked, cache 2 hit gives HIT.
    op_tbl[0] = 2'b00;
    doTxn(4'b0001, 4'b0101, 4'b0, 0, 1'b0, 1'b0);
    // Two owners: error pulse, lowest-index owner (cache 1) writes back.
    doTxn(4'b0001, 4'b0, 4'b0110, 2, 1'b0, 1'b0);
    // Owner plus a plain hit is also a protocol error.
    doTxn(4'b0001, 4'b1000, 4'b0100, 1, 1'b0, 1'b0);
    // Requester's own hitm is masked: plain NOHIT.
    doTxn(4'b0001, 4'b0, 4'b0001, 0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        op_tbl[i]   = 2'($urandom);
        addr_tbl[i] = $urandom;
      end
      r  = 4'($urandom_range(1, 15));
      h  = 4'($urandom);
      hm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      doTxn(r, h, hm, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end

    // Reset during WB: outputs clear at once, no done, pointer back to 0.
    op_tbl[2] = 2'b01;
    applyStimulus(4'b0100, 4'b0, 4'b0010);
    repeat (2 + SNOOP_LAT) @(negedge clk_tb);
    checkOutput("rst_pre_wb", {gnt, wb_req}, {4'b0100, 4'b0010});
    applyStimulus(4'b0, 4'b0, 4'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_async",
                {gnt, done, result, bus_valid, bus_op, bus_addr, bus_src, wb_req, err}, 0);
    repeat (2) begin
      @(negedge clk_tb);
      checkOutput("rst_hold", {gnt, done, result, wb_req, err}, 0);
    end
    reset     = 1'b0;
    ptr_model = 0;
    for (int i = 0; i < N_REQ; i++) op_tbl[i] = 2'b00;
    doTxn(4'b1111, 4'b0, 4'b0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/mesi_bus_arbiter.md
MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of cache requesters.
REQ-002 The block SHALL have parameter ADDR_W, default 32: line address width.
REQ-003 The block SHALL have parameter SNOOP_LAT, default 2 (legal range 1..15): cycles from bus address phase to snoop-response sample.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  clock, all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 req  in  N_REQ  per-cache bus request.
REQ-008 req_op  in  2*N_REQ  per-cache op: 00 READ, 01 RWITM, 10 INVALIDATE, 11 WRITEBACK.
REQ-009 req_addr  in  ADDR_W*N_REQ  per-cache line address.
REQ-010 gnt  out  N_REQ  one-hot grant, high from address phase through done.
REQ-011 done  out  N_REQ  one-cycle completion pulse to granted cache.
REQ-012 result  out  2  snoop result, valid only with done: 00 NOHIT, 01 HIT, 10 HITM; 00 otherwise.
REQ-013 bus_valid, bus_op[2], bus_addr[ADDR_W], bus_src[clog2(N_REQ)]  out  broadcast snoop bus; zero when bus_valid low.
REQ-014 snoop_hit, snoop_hitm  in  N_REQ  per-cache snoop responses.
REQ-015 wb_req  out  N_REQ  writeback request to owning (Modified) cache; wb_done  in  N_REQ  owner acknowledgement.
REQ-016 err  out  1  one-cycle pulse on snoop-response protocol violation.

Function
REQ-017 States SHALL be IDLE, ADDR, SNOOP, WB, DONE.
REQ-018 IDLE: on any req high, the block SHALL select a winner round-robin starting at pointer ptr, latch its op/addr/index, go to ADDR.
REQ-019 After each grant ptr SHALL become (winner+1) mod N_REQ; requests with index >= ptr win before lower indices.
REQ-020 ADDR (one cycle): gnt[winner]=1, bus_valid=1, bus_op/bus_addr/bus_src = latched values; WRITEBACK goes to DONE, all others to SNOOP.
REQ-021 SNOOP SHALL last exactly SNOOP_LAT cycles; in its last cycle snoop_hit/snoop_hitm SHALL be sampled with the winner's own bit masked off.
REQ-022 If any masked hitm: go to WB, result HITM; else go to DONE, result HIT if any masked hit, else NOHIT.
REQ-023 WB: wb_req SHALL be held high to the lowest-index hitm cache only, until its wb_done is seen; then go to DONE (wb_done from other caches ignored).
REQ-024 err SHALL pulse at sample time if >1 masked hitm, or hitm together with any masked hit; the lowest-index owner is still used.
REQ-025 DONE (one cycle): done[winner]=1 with result; next cycle gnt low, state IDLE.
REQ-026 Latency: req at IDLE cycle t -> ADDR at t+1, done at t+2+SNOOP_LAT (no HITM), t+2 for WRITEBACK.
REQ-027 req dropped or op/addr changed after latch SHALL NOT affect the in-flight transaction; req still high in the cycle after done is a new request.
REQ-028 Only one transaction SHALL be in flight; new requests wait in IDLE arbitration.

Reset
REQ-029 Reset SHALL force state IDLE, ptr=0, snoop counter=0, and every output (gnt, done, result, bus_*, wb_req, err) to 0.
REQ-030 Reset mid-transaction SHALL abort it with no done pulse; ptr returns to 0.

Structure
REQ-031 Package mesi_pkg SHALL hold bus_op_t, snoop_result_t, and arbiter state enum encodings.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (req, ptr -> one-hot grant, index).

Verification
REQ-033 req=0001 READ addr 0x40, no snoops -> bus_valid at t+1 with src 0, done[0] at t+4, result NOHIT, ptr=1.
REQ-034 req=1111 held high -> grants in order 0,1,2,3,0; each done before the next ADDR.
REQ-035 Cache 2 RWITM, snoop_hitm=0010 -> wb_req=0010 until wb_done[1] after 5 cycles, then done[2] with HITM.
REQ-036 Cache 0 READ, snoop_hit=0001|0100, hitm=0 -> own bit masked, result HIT; hitm=0110 -> err pulse, wb_req=0010.
REQ-037 Cache 3 WRITEBACK -> done[3] at t+2, result NOHIT, no snoop sample.
REQ-038 Reset asserted during WB -> all outputs 0 asynchronously, no done, next request from cache 0 wins first.
